// File: rtl/serial_adder.sv
// Serial adder: adds CHUNK bits per clock, LSB chunk first.
// Valid/ready on both sides; result held until taken.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   add;
  logic             msb_cin;
  logic             last;
  logic             accept;

  // state and beat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // next state, beat count and handshake outputs
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          beat_d  = '0;
        end
      end
      RUN: begin
        beat_d = beat_q + 1'b1;
        if (last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  assign last   = (beat_q == LAST);
  assign accept = (state_q == IDLE) && in_valid;

  // one chunk of the ripple addition for the current beat
  always_comb begin
    base    = 32'(beat_q) * 32'(CHUNK);
    a_ch    = CHUNK'(a_q >> base);
    b_ch    = CHUNK'(b_q >> base);
    add     = {1'b0, a_ch} + {1'b0, b_ch}
            + (CHUNK + 1)'(carry_q);
    acc_d   = acc_q | (WIDTH'(add[CHUNK-1:0]) << base);
    // carry into the top bit of this chunk, only meaningful on the last beat
    msb_cin = add[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
  end

  // operand capture, running carry, partial sum and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      acc_q   <= '0;
    end else if (state_q == RUN) begin
      carry_q <= add[CHUNK];
      acc_q   <= acc_d;
      if (last) begin
        sum_q  <= acc_d;
        cout_q <= add[CHUNK];
        ovf_q  <= msb_cin ^ add[CHUNK];
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 CHUNK=2 and CHUNK=8 instances.
// Expected results go through a queue and are popped at out_valid.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       iv, ir, ov, ordy, ci, co, of;
  logic [7:0] ain, bin, s;

  logic       b_iv, b_ir, b_ov, b_ordy, b_ci, b_co, b_of;
  logic [7:0] b_a, b_b, b_s;

  int         errors;
  int         checks;
  logic [9:0] sb[$];

  serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .a(ain), .b(bin), .cin(ci),
    .out_valid(ov), .out_ready(ordy),
    .sum(s), .cout(co), .overflow(of)
  );

  serial_adder #(.WIDTH(8), .CHUNK(8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_ready(b_ir),
    .a(b_a), .b(b_b), .cin(b_ci),
    .out_valid(b_ov), .out_ready(b_ordy),
    .sum(b_s), .cout(b_co), .overflow(b_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {overflow, cout, sum}
  function automatic logic [9:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic c);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t};
  endfunction

  function automatic logic [9:0] pop_exp();
    if (sb.size() == 0) return 10'h3ff;
    return sb.pop_front();
  endfunction

  // Called just after a negedge with the DUT in IDLE.
  task automatic op(input logic [7:0] x, input logic [7:0] y,
                    input logic c, input int hold, input bit spam,
                    input logic [7:0] sx, input logic [7:0] sy);
    int         lat;
    logic [9:0] e;
    chk("in_ready_idle", 32'(ir), 32'd1);
    iv = 1'b1; ain = x; bin = y; ci = c;
    sb.push_back(model(x, y, c));
    @(negedge clk);
    if (spam) begin
      ain = sx; bin = sy; ci = ~c;
    end else begin
      iv = 1'b0;
    end
    chk("in_ready_busy", 32'(ir), 32'd0);
    lat = 0;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    e = pop_exp();
    chk("result", 32'({of, co, s}), 32'(e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov), 32'd1);
      chk("hold_data", 32'({of, co, s}), 32'(e));
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("post_ready", 32'(ir), 32'd1);
    chk("post_valid", 32'(ov), 32'd0);
    chk("post_keep", 32'({of, co, s}), 32'(e));
  endtask

  initial begin
    int         lat;
    int         pulses;
    logic [7:0] rx, ry;
    logic       rc;
    errors = 0; checks = 0;
    iv = 0; ordy = 0; ain = 0; bin = 0; ci = 0;
    b_iv = 0; b_ordy = 0; b_a = 0; b_b = 0; b_ci = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_in_ready", 32'(ir), 32'd1);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_outputs", 32'({of, co, s}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'hFF, 8'h01, 1'b0, 0, 0, 8'h00, 8'h00);
    op(8'h80, 8'h80, 1'b0, 0, 0, 8'h00, 8'h00);
    op(8'hFF, 8'hFF, 1'b1, 5, 0, 8'h00, 8'h00);
    op(8'h3C, 8'h55, 1'b0, 1, 1, 8'hA5, 8'h9A);
    op(8'hA5, 8'h9A, 1'b1, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      rx = 8'($urandom); ry = 8'($urandom); rc = 1'($urandom);
      op(rx, ry, rc, int'($urandom_range(0, 3)), 0, 8'h00, 8'h00);
    end
    op(8'h7F, 8'h01, 1'b0, 0, 0, 8'h00, 8'h00);

    // reset mid-operation
    iv = 1'b1; ain = 8'hFF; bin = 8'hFF; ci = 1'b1;
    sb.push_back(model(8'hFF, 8'hFF, 1'b1));
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(ir), 32'd1);
    chk("midrst_valid", 32'(ov), 32'd0);
    chk("midrst_outputs", 32'({of, co, s}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov) pulses++;
    end
    chk("midrst_no_valid", 32'(pulses), 32'd0);
    op(8'hFF, 8'hFF, 1'b1, 0, 0, 8'h00, 8'h00);

    // single-beat instance
    b_iv = 1'b1; b_a = 8'h0F; b_b = 8'hF1; b_ci = 1'b1;
    sb.push_back(model(8'h0F, 8'hF1, 1'b1));
    @(negedge clk);
    b_iv = 1'b0;
    lat = 0;
    while (!b_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w_latency", 32'(lat), 32'd1);
    chk("w_result", 32'({b_of, b_co, b_s}), 32'(pop_exp()));
    chk("w_const", 32'({b_of, b_co, b_s}), 32'h101);
    b_ordy = 1'b1;
    @(negedge clk);
    b_ordy = 1'b0;
    chk("w_post_ready", 32'(b_ir), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 1, bits added per clock cycle.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have in_valid  input  1  operands a, b, cin are presented.
REQ-006 SHALL have in_ready  output  1  block can accept operands.
REQ-007 SHALL have a  input  WIDTH  addend A (unsigned or two's complement).
REQ-008 SHALL have b  input  WIDTH  addend B.
REQ-009 SHALL have cin  input  1  carry-in.
REQ-010 SHALL have out_valid  output  1  result is available.
REQ-011 SHALL have out_ready  input  1  consumer takes the result.
REQ-012 SHALL have sum  output  WIDTH  result bits.
REQ-013 SHALL have cout  output  1  carry out of the MSB.
REQ-014 SHALL have overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 SHALL fail elaboration unless WIDTH >= 1, CHUNK >= 1 and WIDTH % CHUNK == 0; N = WIDTH/CHUNK.
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, HOLD.
REQ-017 IDLE: in_ready=1, out_valid=0; accept on the edge where in_valid=1, capturing a, b and cin, clearing beat counter to 0, and moving to RUN.
REQ-018 RUN: in_ready=0, out_valid=0; each cycle adds operand bits [CHUNK*i +: CHUNK] plus the running carry, LSB chunk first, i = beat counter.
REQ-019 At the edge processing beat N-1, SHALL load sum, cout and overflow from the completed addition and move to HOLD; out_valid first rises exactly N cycles after the accepting edge.
REQ-020 HOLD: out_valid=1, in_ready=0; sum, cout and overflow SHALL stay stable while out_ready=0.
REQ-021 HOLD with out_ready=1 at an edge SHALL complete the transfer and return to IDLE; the next accept can occur no earlier than the following edge.
REQ-022 SHALL ignore in_valid in RUN and HOLD: no capture and no effect on the computation in progress.
REQ-023 SHALL ignore out_ready outside HOLD.
REQ-024 sum, cout and overflow SHALL keep the last result after the transfer until the next HOLD entry.
REQ-025 Result SHALL equal {cout,sum} = a + b + cin modulo 2^(WIDTH+1) for all operands, including all-ones inputs with cin=1.
REQ-026 CHUNK=WIDTH (N=1) SHALL work: RUN lasts one cycle, and out_valid rises one cycle after accept.
REQ-027 Beat counter SHALL be ceil(log2(N+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, beat counter 0, in_ready=1, and out_valid, sum, cout and overflow to 0, regardless of clk.
REQ-029 Reset asserted in RUN or HOLD SHALL abandon the operation with no out_valid pulse; the first edge after rst_n rises may accept new operands.
REQ-030 Operand and carry registers SHALL clear to 0 on reset.

Verification (WIDTH=8, CHUNK=2, N=4 unless stated)
REQ-031 a=8'hFF, b=8'h01, cin=0 -> out_valid 4 cycles after accept; sum=8'h00, cout=1, overflow=0.
REQ-032 a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
REQ-033 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and sum held constant; out_ready=1 -> IDLE next cycle with in_ready=1.
REQ-034 in_valid held high with new operands during RUN -> the first result is unchanged, and the second operation is accepted only in IDLE.
REQ-035 rst_n pulsed low at beat 2 of a=8'hFF, b=8'hFF, cin=1 -> outputs 0 at once, no out_valid; a rerun gives sum=8'hFF, cout=1.
REQ-036 CHUNK=8: a=8'h0F, b=8'hF1, cin=1 -> out_valid 1 cycle after accept; sum=8'h01, cout=1, overflow=0.
